// File: rtl/mux_scan_ctrl.sv
// Channel scanner for an N-bit MUX: drives a latched word on w, sweeps s,
// samples f back per channel and reports the rebuilt word and a loopback match.
// Optional macro SCAN_PARITY_EN adds a parity_err output.
module mux_scan_ctrl #(
    parameter int N     = 4,
    parameter int DWELL = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N-1:0]         w_in,
    input  logic                 f,
    output logic [N-1:0]         w,
    output logic [$clog2(N)-1:0] s,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         data_out,
    output logic                 match,
`ifdef SCAN_PARITY_EN
    output logic                 parity_err,
`endif
    output logic [1:0]           state_dbg
);

    localparam int SW = $clog2(N);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [SW-1:0] S_LAST   = SW'(N - 1);
    localparam logic [SW-1:0] S_ONE    = SW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  capture;
    logic [N-1:0]  cap_next;

    // Capture with the current channel's sample merged in; this is what
    // data_out loads on the final sample so it is valid in the done cycle.
    always_comb begin
        cap_next    = capture;
        cap_next[s] = f;
    end

    assign busy      = (state == SCAN);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            w        <= '0;
            s        <= '0;
            cnt      <= '0;
            capture  <= '0;
            data_out <= '0;
            match    <= 1'b0;
`ifdef SCAN_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        w       <= w_in;
                        s       <= '0;
                        cnt     <= '0;
                        capture <= '0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        capture <= cap_next;
                        // s stops at N-1 so it never leaves the valid channel range.
                        if (s == S_LAST) begin
                            state    <= DONE;
                            data_out <= cap_next;
                            match    <= (cap_next == w);
`ifdef SCAN_PARITY_EN
                            parity_err <= ((^cap_next) != (^w));
`endif
                        end else begin
                            s <= s + S_ONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (N=4/DWELL=1, N=4/DWELL=3, N=3/DWELL=1)
// with a behavioural MUX model on f, one active at a time.
module tb_mux_scan_ctrl;

    logic clk;
    logic rst_n;
    logic start;
    logic [3:0] w_in;
    int   sel;
    bit   inv_f;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [5:0] exp_q[$];
    logic [3:0] last_data [3];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic       start_a, start_b, start_c;
    logic       f_a, f_b, f_c;
    logic [3:0] w_a, w_b;
    logic [2:0] w_c;
    logic [1:0] s_a, s_b, s_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [3:0] d_a, d_b;
    logic [2:0] d_c;
    logic       m_a, m_b, m_c;
    logic [1:0] st_a, st_b, st_c;
`ifdef SCAN_PARITY_EN
    logic       p_a, p_b, p_c;
`endif

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    // MUX model, with optional inversion of channel 2 to emulate a fault.
    assign f_a = w_a[s_a] ^ (inv_f && (s_a == 2'd2));
    assign f_b = w_b[s_b] ^ (inv_f && (s_b == 2'd2));
    assign f_c = w_c[s_c] ^ (inv_f && (s_c == 2'd2));

    mux_scan_ctrl #(.N(4), .DWELL(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .w_in(w_in), .f(f_a),
        .w(w_a), .s(s_a), .busy(busy_a), .done(done_a), .data_out(d_a), .match(m_a),
`ifdef SCAN_PARITY_EN
        .parity_err(p_a),
`endif
        .state_dbg(st_a)
    );

    mux_scan_ctrl #(.N(4), .DWELL(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .w_in(w_in), .f(f_b),
        .w(w_b), .s(s_b), .busy(busy_b), .done(done_b), .data_out(d_b), .match(m_b),
`ifdef SCAN_PARITY_EN
        .parity_err(p_b),
`endif
        .state_dbg(st_b)
    );

    mux_scan_ctrl #(.N(3), .DWELL(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .w_in(w_in[2:0]), .f(f_c),
        .w(w_c), .s(s_c), .busy(busy_c), .done(done_c), .data_out(d_c), .match(m_c),
`ifdef SCAN_PARITY_EN
        .parity_err(p_c),
`endif
        .state_dbg(st_c)
    );

    // Observation mux onto the selected instance.
    logic [3:0] obs_w, obs_data;
    logic [1:0] obs_s, obs_state;
    logic       obs_busy, obs_done, obs_match, obs_par;

    always_comb begin
        obs_w = w_a; obs_s = s_a; obs_busy = busy_a; obs_done = done_a;
        obs_data = d_a; obs_match = m_a; obs_state = st_a; obs_par = 1'b0;
`ifdef SCAN_PARITY_EN
        obs_par = p_a;
`endif
        case (sel)
            1: begin
                obs_w = w_b; obs_s = s_b; obs_busy = busy_b; obs_done = done_b;
                obs_data = d_b; obs_match = m_b; obs_state = st_b;
`ifdef SCAN_PARITY_EN
                obs_par = p_b;
`endif
            end
            2: begin
                obs_w = {1'b0, w_c}; obs_s = s_c; obs_busy = busy_c; obs_done = done_c;
                obs_data = {1'b0, d_c}; obs_match = m_c; obs_state = st_c;
`ifdef SCAN_PARITY_EN
                obs_par = p_c;
`endif
            end
            default: ;
        endcase
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input int got, input int expv);
        vec_cnt++;
        if (got !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Scoreboard: one expected {parity, match, data} per accepted scan.
    always @(negedge clk) begin
        logic [5:0] e;
        if (rst_n && obs_done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("data_out", int'(obs_data), int'(e[3:0]));
                check("match", int'(obs_match), int'(e[4]));
`ifdef SCAN_PARITY_EN
                check("parity_err", int'(obs_par), int'(e[5]));
`endif
                last_data[sel] = e[3:0];
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_scan(input int inst, input logic [3:0] word, input bit inv, input bit repulse);
        int n, dw, busy_cnt;
        bit got_done;
        logic [3:0] mask, wv, ed;
        sel  = inst;
        n    = (inst == 2) ? 3 : 4;
        dw   = (inst == 1) ? 3 : 1;
        mask = (inst == 2) ? 4'h7 : 4'hF;
        wv   = word & mask;
        ed   = wv ^ (inv ? 4'b0100 : 4'b0000);
        exp_q.push_back({inv, ~inv, ed});
        inv_f = inv;
        @(negedge clk);
        start = 1'b1;
        w_in  = wv;
        @(posedge clk);
        #1;
        start = 1'b0;
        w_in  = 4'($urandom_range(0, 15)) & mask;
        busy_cnt = 0;
        got_done = 0;
        for (int i = 1; i <= n * dw + 5 && !got_done; i++) begin
            @(negedge clk);
            if (obs_done) begin
                got_done = 1;
                check("latency", i, n * dw + 1);
            end else begin
                if (i == 1) check("data_hold", int'(obs_data), int'(last_data[inst]));
                check("s_seq", int'(obs_s), (i - 1) / dw);
                check("w_stable", int'(obs_w), int'(wv));
                if (obs_busy) busy_cnt++;
            end
            if (repulse && i == 2) begin
                start = 1'b1;
                w_in  = 4'h7;
            end else begin
                start = 1'b0;
            end
        end
        if (!got_done) check("done_timeout", 0, 1);
        check("busy_cycles", busy_cnt, n * dw);
        inv_f = 1'b0;
        @(negedge clk);
        check("idle_busy", int'(obs_busy), 0);
        check("s_hold", int'(obs_s), n - 1);
        check("w_hold", int'(obs_w), int'(wv));
    endtask

    task automatic reset_mid_scan();
        bit hit;
        sel = 0;
        @(negedge clk);
        start = 1'b1;
        w_in  = 4'h9;
        @(posedge clk);
        #1;
        start = 1'b0;
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (obs_s == 2'd2) hit = 1;
        end
        if (!hit) check("s2_timeout", 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_w", int'(obs_w), 0);
        check("rst_s", int'(obs_s), 0);
        check("rst_busy", int'(obs_busy), 0);
        check("rst_done", int'(obs_done), 0);
        check("rst_data", int'(obs_data), 0);
        check("rst_match", int'(obs_match), 0);
        check("rst_state", int'(obs_state), 0);
        for (int i = 0; i < 3; i++) last_data[i] = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_idle", int'(obs_busy), 0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        w_in  = 4'h0;
        sel   = 0;
        inv_f = 1'b0;
        for (int i = 0; i < 3; i++) last_data[i] = 4'h0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            check("reset_w", int'(obs_w), 0);
            check("reset_s", int'(obs_s), 0);
            check("reset_busy", int'(obs_busy), 0);
            check("reset_done", int'(obs_done), 0);
            check("reset_data", int'(obs_data), 0);
            check("reset_match", int'(obs_match), 0);
`ifdef SCAN_PARITY_EN
            check("reset_parity", int'(obs_par), 0);
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_scan(0, 4'd8, 1'b0, 1'b0);
        run_scan(1, 4'd11, 1'b0, 1'b0);
        run_scan(0, 4'd8, 1'b1, 1'b0);
        run_scan(0, 4'd8, 1'b0, 1'b1);
        run_scan(0, 4'd7, 1'b0, 1'b0);
        reset_mid_scan();
        run_scan(0, 4'd3, 1'b0, 1'b0);
        run_scan(2, 4'b0101, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            run_scan(int'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
